// File: rtl/gt_reset_sequencer.sv
// GT/DCMAC link bring-up and recovery sequencer: full GT reset, per-port RX datapath resets, retry escalation.
// Optional GT_RESET_STATS_EN adds per-port saturating link-drop counters on output link_drops.
module gt_reset_sequencer #(
    parameter int NUM_PORTS     = 2,
    parameter int RESET_CYCLES  = 64,
    parameter int DONE_TIMEOUT  = 2000000,
    parameter int ALIGN_TIMEOUT = 4000000,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                   s_axi_clk,
    input  logic                   reset,
    input  logic                   gtpowergood,
    input  logic [NUM_PORTS-1:0]   gt_rx_reset_done,
    input  logic [NUM_PORTS-1:0]   rx_aligned,
    input  logic                   sw_reset_all,
    output logic                   user_gt_reset_all,
    output logic [NUM_PORTS-1:0]   user_gt_reset_rx_datapath,
    output logic [NUM_PORTS-1:0]   link_up,
    output logic [3*NUM_PORTS-1:0] retry_count,
    output logic [7:0]             escalations
`ifdef GT_RESET_STATS_EN
    ,
    output logic [16*NUM_PORTS-1:0] link_drops
`endif
);

    localparam logic [31:0] RESET_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] DONE_LAST   = 32'(DONE_TIMEOUT - 1);
    localparam logic [31:0] ALIGN_LAST  = 32'(ALIGN_TIMEOUT - 1);
    localparam logic [31:0] RETRY_LIMIT = 32'(MAX_RETRIES);

    typedef enum logic [1:0] {
        G_POWER,
        G_RESET_ALL,
        G_RUN
    } g_state_t;

    typedef enum logic [1:0] {
        P_WAIT_DONE,
        P_WAIT_ALIGN,
        P_UP,
        P_DP_RESET
    } p_state_t;

    g_state_t             g_state_reg, g_state_next;
    logic [31:0]          g_timer_reg, g_timer_next;
    logic                 reset_all_reg, reset_all_next;
    logic [7:0]           escalations_reg, escalations_next;
    logic [NUM_PORTS-1:0] esc_req;
    logic                 ports_active;

    // Global FSM: powergood loss outranks everything and is not counted as an escalation.
    always_comb begin
        g_state_next     = g_state_reg;
        g_timer_next     = '0;
        escalations_next = escalations_reg;
        if (!gtpowergood) begin
            g_state_next = G_POWER;
        end else begin
            case (g_state_reg)
                G_POWER: begin
                    g_state_next = G_RESET_ALL;
                end
                G_RESET_ALL: begin
                    if (g_timer_reg == RESET_LAST) begin
                        g_state_next = G_RUN;
                    end else begin
                        g_timer_next = g_timer_reg + 32'd1;
                    end
                end
                G_RUN: begin
                    if ((|esc_req) || sw_reset_all) begin
                        g_state_next = G_RESET_ALL;
                        if (escalations_reg != 8'hFF) begin
                            escalations_next = escalations_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    g_state_next = G_POWER;
                end
            endcase
        end
        reset_all_next = (g_state_next != G_RUN);
    end

    always_ff @(posedge s_axi_clk) begin
        if (reset) begin
            g_state_reg     <= G_POWER;
            g_timer_reg     <= '0;
            reset_all_reg   <= 1'b1;
            escalations_reg <= '0;
        end else begin
            g_state_reg     <= g_state_next;
            g_timer_reg     <= g_timer_next;
            reset_all_reg   <= reset_all_next;
            escalations_reg <= escalations_next;
        end
    end

    // Ports only advance when the global FSM stays in G_RUN, so a reset_all entry wins over any port move.
    assign ports_active      = (g_state_reg == G_RUN) && (g_state_next == G_RUN);
    assign user_gt_reset_all = reset_all_reg;
    assign escalations       = escalations_reg;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        p_state_t    state_reg, state_next, state_raw;
        logic [31:0] timer_reg, timer_next;
        logic [2:0]  retry_reg, retry_next;
        logic        dp_reg, dp_next;
        logic        link_reg, link_next;
        logic        fail;
        logic        done_in, aligned_in;

        assign done_in    = gt_rx_reset_done[gi];
        assign aligned_in = rx_aligned[gi];

        // Free-running decision, independent of the global FSM, so the escalation path has no loop.
        always_comb begin
            state_raw = state_reg;
            fail      = 1'b0;
            case (state_reg)
                P_WAIT_DONE: begin
                    if (done_in) begin
                        state_raw = P_WAIT_ALIGN;
                    end else if (timer_reg == DONE_LAST) begin
                        fail = 1'b1;
                    end
                end
                P_WAIT_ALIGN: begin
                    if (aligned_in) begin
                        state_raw = P_UP;
                    end else if (!done_in) begin
                        state_raw = P_WAIT_DONE;
                    end else if (timer_reg == ALIGN_LAST) begin
                        fail = 1'b1;
                    end
                end
                P_UP: begin
                    if (!aligned_in || !done_in) begin
                        fail = 1'b1;
                    end
                end
                P_DP_RESET: begin
                    if (timer_reg == RESET_LAST) begin
                        state_raw = P_WAIT_DONE;
                    end
                end
                default: begin
                    state_raw = P_WAIT_DONE;
                end
            endcase
            if (fail) begin
                state_raw = P_DP_RESET;
            end
        end

        // A failure with the retry budget exhausted asks for reset_all instead of another datapath pulse.
        assign esc_req[gi] = fail && (g_state_reg == G_RUN) && (32'(retry_reg) == RETRY_LIMIT);

        always_comb begin
            state_next = P_WAIT_DONE;
            timer_next = '0;
            retry_next = '0;
            if (ports_active) begin
                state_next = state_raw;
                retry_next = retry_reg;
                if (state_next == state_reg) begin
                    timer_next = (timer_reg == 32'hFFFF_FFFF) ? timer_reg : timer_reg + 32'd1;
                end
                if (state_next == P_UP) begin
                    retry_next = '0;
                end else if ((state_next == P_DP_RESET) && (state_reg != P_DP_RESET)
                             && (retry_reg != 3'd7)) begin
                    retry_next = retry_reg + 3'd1;
                end
            end
            dp_next   = (state_next == P_DP_RESET);
            link_next = (state_next == P_UP);
        end

        always_ff @(posedge s_axi_clk) begin
            if (reset) begin
                state_reg <= P_WAIT_DONE;
                timer_reg <= '0;
                retry_reg <= '0;
                dp_reg    <= 1'b0;
                link_reg  <= 1'b0;
            end else begin
                state_reg <= state_next;
                timer_reg <= timer_next;
                retry_reg <= retry_next;
                dp_reg    <= dp_next;
                link_reg  <= link_next;
            end
        end

        assign user_gt_reset_rx_datapath[gi] = dp_reg;
        assign link_up[gi]                   = link_reg;
        assign retry_count[3*gi +: 3]        = retry_reg;

`ifdef GT_RESET_STATS_EN
        logic [15:0] drops_reg;

        // Survives reset_all; only the module reset clears it.
        always_ff @(posedge s_axi_clk) begin
            if (reset) begin
                drops_reg <= '0;
            end else if ((state_reg == P_UP) && (state_next == P_DP_RESET)
                         && (drops_reg != 16'hFFFF)) begin
                drops_reg <= drops_reg + 16'd1;
            end
        end

        assign link_drops[16*gi +: 16] = drops_reg;
`endif
    end

endmodule

// File: tb/tb_gt_reset_sequencer.sv
// Directed bench for gt_reset_sequencer: expectations are queued as stimulus is applied and popped when outputs are sampled.
module tb_gt_reset_sequencer;

    logic       s_axi_clk = 1'b0;
    logic       reset;
    logic       gtpowergood;
    logic [1:0] gt_rx_reset_done;
    logic [1:0] rx_aligned;
    logic       sw_reset_all;
    logic       user_gt_reset_all;
    logic [1:0] user_gt_reset_rx_datapath;
    logic [1:0] link_up;
    logic [5:0] retry_count;
    logic [7:0] escalations;
`ifdef GT_RESET_STATS_EN
    logic [31:0] link_drops;
`endif

    always #5 s_axi_clk = ~s_axi_clk;

    gt_reset_sequencer #(
        .NUM_PORTS    (2),
        .RESET_CYCLES (4),
        .DONE_TIMEOUT (20),
        .ALIGN_TIMEOUT(30),
        .MAX_RETRIES  (2)
    ) dut (
        .s_axi_clk                (s_axi_clk),
        .reset                    (reset),
        .gtpowergood              (gtpowergood),
        .gt_rx_reset_done         (gt_rx_reset_done),
        .rx_aligned               (rx_aligned),
        .sw_reset_all             (sw_reset_all),
        .user_gt_reset_all        (user_gt_reset_all),
        .user_gt_reset_rx_datapath(user_gt_reset_rx_datapath),
        .link_up                  (link_up),
        .retry_count              (retry_count),
        .escalations              (escalations)
`ifdef GT_RESET_STATS_EN
        ,
        .link_drops               (link_drops)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge s_axi_clk);
            #1;
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
            $display("check %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic exp3(input string tag, input logic ra, input logic [1:0] dp, input logic [1:0] lu);
        expect_val({tag, "_reset_all"}, 32'(ra));
        expect_val({tag, "_rx_datapath"}, 32'(dp));
        expect_val({tag, "_link_up"}, 32'(lu));
    endtask

    task automatic obs3();
        check(32'(user_gt_reset_all));
        check(32'(user_gt_reset_rx_datapath));
        check(32'(link_up));
    endtask

    initial begin
        reset            = 1'b1;
        gtpowergood      = 1'b0;
        gt_rx_reset_done = 2'b00;
        rx_aligned       = 2'b00;
        sw_reset_all     = 1'b0;
        step(3);
        exp3("rst", 1'b1, 2'b00, 2'b00);
        expect_val("rst_retry", 0);
        expect_val("rst_esc", 0);
        obs3();
        check(32'(retry_count));
        check(32'(escalations));
        reset = 1'b0;

        // Power-up: held in reset_all until powergood, then exactly 4 more cycles.
        step(10);
        exp3("pg_wait", 1'b1, 2'b00, 2'b00);
        obs3();
        gtpowergood = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_val("pu_reset_all_hi", 1);
            step();
            check(32'(user_gt_reset_all));
        end
        expect_val("pu_reset_all_fall", 0);
        step();
        check(32'(user_gt_reset_all));
        step(2);
        gt_rx_reset_done = 2'b11;
        step(5);
        expect_val("pu_pre_link", 0);
        check(32'(link_up));
        rx_aligned = 2'b11;
        expect_val("pu_link_up", 3);
        step();
        check(32'(link_up));

        // Link drop on port0.
        rx_aligned = 2'b10;
        exp3("drop", 1'b0, 2'b01, 2'b10);
        expect_val("drop_retry", 6'o01);
        step();
        obs3();
        check(32'(retry_count));
        rx_aligned = 2'b11;
        expect_val("drop_dp_hold", 1);
        step(3);
        check(32'(user_gt_reset_rx_datapath));
        expect_val("drop_dp_end", 0);
        step();
        check(32'(user_gt_reset_rx_datapath));
        expect_val("drop_relink", 3);
        expect_val("drop_retry_clr", 0);
        step(2);
        check(32'(link_up));
        check(32'(retry_count));
`ifdef GT_RESET_STATS_EN
        expect_val("drop_count", 32'h0000_0001);
        check(link_drops);
`endif

        // sw_reset_all while port0 is mid datapath pulse.
        rx_aligned = 2'b10;
        step();
        rx_aligned = 2'b11;
        expect_val("sw_pre_dp", 1);
        check(32'(user_gt_reset_rx_datapath));
        step();
        sw_reset_all = 1'b1;
        exp3("sw", 1'b1, 2'b00, 2'b00);
        expect_val("sw_esc", 1);
        step();
        sw_reset_all = 1'b0;
        obs3();
        check(32'(escalations));
        gt_rx_reset_done = 2'b11;
        rx_aligned       = 2'b10;
        expect_val("sw_ra_hold", 1);
        step(3);
        check(32'(user_gt_reset_all));
        expect_val("sw_ra_fall", 0);
        step();
        check(32'(user_gt_reset_all));

        // Align timeout on port0; port1 comes up and stays up.
        exp3("align_wait", 1'b0, 2'b00, 2'b10);
        step(30);
        obs3();
        exp3("align_to", 1'b0, 2'b01, 2'b10);
        expect_val("align_retry", 6'o01);
        step();
        obs3();
        check(32'(retry_count));
        expect_val("align_dp_hold", 1);
        step(3);
        check(32'(user_gt_reset_rx_datapath));
        expect_val("align_dp_end", 0);
        step();
        check(32'(user_gt_reset_rx_datapath));
        rx_aligned = 2'b11;
        expect_val("align_relink", 3);
        expect_val("align_retry_clr", 0);
        step(2);
        check(32'(link_up));
        check(32'(retry_count));

        // Escalation: port1 reset_done stuck low.
        gt_rx_reset_done = 2'b01;
        rx_aligned       = 2'b01;
        exp3("esc_fail1", 1'b0, 2'b10, 2'b01);
        expect_val("esc_retry1", 6'o10);
        step();
        obs3();
        check(32'(retry_count));
        expect_val("esc_dp1_hold", 2);
        step(3);
        check(32'(user_gt_reset_rx_datapath));
        expect_val("esc_dp1_end", 0);
        step();
        check(32'(user_gt_reset_rx_datapath));
        expect_val("esc_wait2", 0);
        step(19);
        check(32'(user_gt_reset_rx_datapath));
        expect_val("esc_dp2", 2);
        expect_val("esc_retry2", 6'o20);
        step();
        check(32'(user_gt_reset_rx_datapath));
        check(32'(retry_count));
        expect_val("esc_dp2_hold", 2);
        step(3);
        check(32'(user_gt_reset_rx_datapath));
        expect_val("esc_dp2_end", 0);
        step();
        check(32'(user_gt_reset_rx_datapath));
        expect_val("esc_pre_ra", 0);
        expect_val("esc_retry_sat", 6'o20);
        step(19);
        check(32'(user_gt_reset_all));
        check(32'(retry_count));
        exp3("esc_ra", 1'b1, 2'b00, 2'b00);
        expect_val("esc_count", 2);
        step();
        obs3();
        check(32'(escalations));
`ifdef GT_RESET_STATS_EN
        expect_val("esc_drops_kept", 32'h0001_0002);
        check(link_drops);
`endif
        gt_rx_reset_done = 2'b11;
        rx_aligned       = 2'b11;
        expect_val("esc_ra_hold", 1);
        step(3);
        check(32'(user_gt_reset_all));
        expect_val("esc_ra_fall", 0);
        step();
        check(32'(user_gt_reset_all));
        expect_val("esc_relink", 3);
        step(2);
        check(32'(link_up));

        // Powergood loss in G_RUN.
        gtpowergood = 1'b0;
        exp3("pgl", 1'b1, 2'b00, 2'b00);
        expect_val("pgl_esc", 2);
        step();
        obs3();
        check(32'(escalations));
        expect_val("pgl_hold", 1);
        step(5);
        check(32'(user_gt_reset_all));
        gtpowergood = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_val("pgl_ra_hi", 1);
            step();
            check(32'(user_gt_reset_all));
        end
        expect_val("pgl_ra_fall", 0);
        expect_val("pgl_esc_after", 2);
        step();
        check(32'(user_gt_reset_all));
        check(32'(escalations));

        // Module reset during an in-progress datapath pulse.
        step(2);
        rx_aligned = 2'b10;
        step();
        rx_aligned = 2'b11;
        reset      = 1'b1;
        exp3("midrst", 1'b1, 2'b00, 2'b00);
        expect_val("midrst_retry", 0);
        expect_val("midrst_esc", 0);
        step();
        obs3();
        check(32'(retry_count));
        check(32'(escalations));
`ifdef GT_RESET_STATS_EN
        expect_val("midrst_drops", 0);
        check(link_drops);
`endif

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
